// File: rtl/v_list_engine.sv
// v_list_engine: per-context sorted {key,size} lists with backpressured updates, level-0 notify and level lookup
// Ports: clk/rst (async, active high); i_upd_* update request with o_upd_rdy handshake;
// i_lut_* lookup request -> o_lut_* registered response; o_lv0_* head-change pulse;
// o_upd_err_* rejection pulse; o_busy_r high while an update executes.
module v_list_engine #(
  parameter int CONTEXT_N  = 16,
  parameter int ENTRIES_N  = 4,
  parameter int ID_W       = 8,
  parameter int KEY_W      = 32,
  parameter int SIZE_W     = 32,
  parameter bit ORDER_DESC = 1'b0,
  localparam int LVL_W = $clog2(ENTRIES_N),
  localparam int LS_W  = $clog2(ENTRIES_N + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_upd_vld,
  output logic              o_upd_rdy,
  input  logic [ID_W-1:0]   i_upd_prod_id,
  input  logic [1:0]        i_upd_cmd,
  input  logic [KEY_W-1:0]  i_upd_key,
  input  logic [SIZE_W-1:0] i_upd_size,
  input  logic              i_lut_vld,
  input  logic [ID_W-1:0]   i_lut_prod_id,
  input  logic [LVL_W-1:0]  i_lut_level,
  output logic              o_lut_vld,
  output logic [KEY_W-1:0]  o_lut_key,
  output logic [SIZE_W-1:0] o_lut_size,
  output logic              o_lut_error,
  output logic [LS_W-1:0]   o_lut_listsize,
  output logic              o_lv0_vld,
  output logic [ID_W-1:0]   o_lv0_prod_id,
  output logic [KEY_W-1:0]  o_lv0_key,
  output logic [SIZE_W-1:0] o_lv0_size,
  output logic              o_lv0_empty,
  output logic              o_upd_err_vld,
  output logic [1:0]        o_upd_err_code,
  output logic              o_busy_r
);
  localparam int CX_W = CONTEXT_N > 1 ? $clog2(CONTEXT_N) : 1;
  localparam logic [1:0] E_BADID = 2'd0, E_FULL = 2'd1, E_DUP = 2'd2, E_NOTFOUND = 2'd3;
  typedef enum logic [1:0] {C_CLEAR, C_ADD, C_DELETE, C_REPLACE} cmd_t;
  typedef enum logic {IDLE, EXEC} state_t;
  state_t state, state_n;
  cmd_t cmd_r;
  logic [ID_W-1:0]   id_r;
  logic [KEY_W-1:0]  key_r;
  logic [SIZE_W-1:0] size_r;
  // Unused slots are kept at zero so the head reads 0/0 on an empty list
  logic [KEY_W-1:0]  keys  [CONTEXT_N][ENTRIES_N];
  logic [SIZE_W-1:0] sizes [CONTEXT_N][ENTRIES_N];
  logic [LS_W-1:0]   cnt   [CONTEXT_N];
  logic              bad, hit, err, notify;
  logic [CX_W-1:0]   ci;
  logic [LS_W-1:0]   n, nn, pos;
  logic [LVL_W-1:0]  hp;
  logic [1:0]        code;
  logic [KEY_W-1:0]  nk [ENTRIES_N];
  logic [SIZE_W-1:0] ns [ENTRIES_N];
  logic              lbad, lerr;
  logic [CX_W-1:0]   lci;
  always_comb begin
    state_n   = state;
    o_upd_rdy = 1'b0;
    o_busy_r  = 1'b0;
    if (state == IDLE) begin
      o_upd_rdy = 1'b1;
      state_n   = i_upd_vld ? EXEC : IDLE;
    end else begin
      o_busy_r = 1'b1;
      state_n  = IDLE;
    end
  end
  always_comb begin
    bad = {1'b0, id_r} >= (ID_W + 1)'(CONTEXT_N);
    ci  = bad ? '0 : id_r[CX_W-1:0];
    n   = cnt[ci];
    hit = 1'b0;
    hp  = '0;
    pos = '0;
    for (int i = 0; i < ENTRIES_N; i++) begin
      if (LS_W'(i) < n) begin
        if (keys[ci][i] == key_r) begin
          hit = 1'b1;
          hp  = LVL_W'(i);
        end
        // Sorted list: insertion point is the number of entries that stay ahead of the new key
        if (ORDER_DESC ? keys[ci][i] > key_r : keys[ci][i] < key_r) pos = pos + 1'b1;
      end
    end
    nk   = keys[ci];
    ns   = sizes[ci];
    nn   = n;
    err  = 1'b0;
    code = E_BADID;
    if (bad) begin
      err = 1'b1;
    end else begin
      case (cmd_r)
        C_CLEAR: begin
          nn = '0;
          for (int i = 0; i < ENTRIES_N; i++) begin
            nk[i] = '0;
            ns[i] = '0;
          end
        end
        C_ADD: begin
          if (n == LS_W'(ENTRIES_N)) begin
            err  = 1'b1;
            code = E_FULL;
          end else if (hit) begin
            err  = 1'b1;
            code = E_DUP;
          end else begin
            nn = n + 1'b1;
            for (int i = ENTRIES_N - 1; i > 0; i--)
              if (LS_W'(i) > pos) begin
                nk[i] = keys[ci][i-1];
                ns[i] = sizes[ci][i-1];
              end
            for (int i = 0; i < ENTRIES_N; i++)
              if (LS_W'(i) == pos) begin
                nk[i] = key_r;
                ns[i] = size_r;
              end
          end
        end
        C_DELETE: begin
          if (!hit) begin
            err  = 1'b1;
            code = E_NOTFOUND;
          end else begin
            nn = n - 1'b1;
            for (int i = 0; i < ENTRIES_N - 1; i++)
              if (LVL_W'(i) >= hp) begin
                nk[i] = keys[ci][i+1];
                ns[i] = sizes[ci][i+1];
              end
            nk[ENTRIES_N-1] = '0;
            ns[ENTRIES_N-1] = '0;
          end
        end
        default: begin
          if (!hit) begin
            err  = 1'b1;
            code = E_NOTFOUND;
          end else begin
            ns[hp] = size_r;
          end
        end
      endcase
    end
    // Head changed, or list crossed between empty and non-empty (covers a 0/0 entry)
    notify = !err && (((n == '0) != (nn == '0)) || nk[0] != keys[ci][0] || ns[0] != sizes[ci][0]);
  end
  always_comb begin
    lbad = {1'b0, i_lut_prod_id} >= (ID_W + 1)'(CONTEXT_N);
    lci  = lbad ? '0 : i_lut_prod_id[CX_W-1:0];
    lerr = lbad || LS_W'(i_lut_level) >= cnt[lci];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      cmd_r          <= C_CLEAR;
      id_r           <= '0;
      key_r          <= '0;
      size_r         <= '0;
      o_lv0_vld      <= 1'b0;
      o_lv0_prod_id  <= '0;
      o_lv0_key      <= '0;
      o_lv0_size     <= '0;
      o_lv0_empty    <= 1'b0;
      o_upd_err_vld  <= 1'b0;
      o_upd_err_code <= '0;
      o_lut_vld      <= 1'b0;
      o_lut_key      <= '0;
      o_lut_size     <= '0;
      o_lut_error    <= 1'b0;
      o_lut_listsize <= '0;
      for (int c = 0; c < CONTEXT_N; c++) begin
        cnt[c] <= '0;
        for (int e = 0; e < ENTRIES_N; e++) begin
          keys[c][e]  <= '0;
          sizes[c][e] <= '0;
        end
      end
    end else begin
      state         <= state_n;
      o_lv0_vld     <= 1'b0;
      o_upd_err_vld <= 1'b0;
      if (state == IDLE && i_upd_vld) begin
        cmd_r  <= cmd_t'(i_upd_cmd);
        id_r   <= i_upd_prod_id;
        key_r  <= i_upd_key;
        size_r <= i_upd_size;
      end
      if (state == EXEC) begin
        if (!err) begin
          cnt[ci]   <= nn;
          keys[ci]  <= nk;
          sizes[ci] <= ns;
        end
        if (notify) begin
          o_lv0_vld     <= 1'b1;
          o_lv0_prod_id <= id_r;
          o_lv0_key     <= nk[0];
          o_lv0_size    <= ns[0];
          o_lv0_empty   <= nn == '0;
        end
        if (err) begin
          o_upd_err_vld  <= 1'b1;
          o_upd_err_code <= code;
        end
      end
      o_lut_vld <= i_lut_vld;
      if (i_lut_vld) begin
        o_lut_error    <= lerr;
        o_lut_listsize <= lbad ? '0 : cnt[lci];
        o_lut_key      <= lerr ? '0 : keys[lci][i_lut_level];
        o_lut_size     <= lerr ? '0 : sizes[lci][i_lut_level];
      end
    end
  end
endmodule

// File: tb/tb_v_list_engine.sv
// tb_v_list_engine: directed self-checking bench for v_list_engine (default parameters)
module tb_v_list_engine;
  logic        clk = 1'b0, rst = 1'b1;
  logic        upd_vld = 1'b0, upd_rdy;
  logic [7:0]  upd_id = '0;
  logic [1:0]  upd_cmd = '0;
  logic [31:0] upd_key = '0, upd_size = '0;
  logic        lut_vld = 1'b0;
  logic [7:0]  lut_id = '0;
  logic [1:0]  lut_level = '0;
  logic        lut_rvld, lut_err, lv0_vld, lv0_empty, err_vld, busy;
  logic [31:0] lut_key, lut_size, lv0_key, lv0_size;
  logic [2:0]  lut_ls;
  logic [7:0]  lv0_id;
  logic [1:0]  err_code;
  int n_cmp = 0, n_bad = 0;
  logic        c_lv, c_em, c_ev;
  logic [31:0] c_k, c_s;
  logic [1:0]  c_ec;
  logic [7:0]  c_id;
  logic        r_err;
  logic [31:0] r_k, r_s;
  logic [2:0]  r_ls;

  v_list_engine dut (
    .clk(clk), .rst(rst), .i_upd_vld(upd_vld), .o_upd_rdy(upd_rdy),
    .i_upd_prod_id(upd_id), .i_upd_cmd(upd_cmd), .i_upd_key(upd_key), .i_upd_size(upd_size),
    .i_lut_vld(lut_vld), .i_lut_prod_id(lut_id), .i_lut_level(lut_level),
    .o_lut_vld(lut_rvld), .o_lut_key(lut_key), .o_lut_size(lut_size), .o_lut_error(lut_err),
    .o_lut_listsize(lut_ls), .o_lv0_vld(lv0_vld), .o_lv0_prod_id(lv0_id), .o_lv0_key(lv0_key),
    .o_lv0_size(lv0_size), .o_lv0_empty(lv0_empty), .o_upd_err_vld(err_vld),
    .o_upd_err_code(err_code), .o_busy_r(busy)
  );

  always #5 clk = ~clk;

  task automatic upd(input logic [7:0] id, input logic [1:0] cmd, input logic [31:0] key, input logic [31:0] size);
    int t = 0;
    @(negedge clk);
    while (!upd_rdy && t < 10) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (upd_rdy !== 1'b1) begin
      n_bad++;
      $display("FAIL rdy_timeout got %b exp 1", upd_rdy);
    end
    upd_vld = 1'b1; upd_id = id; upd_cmd = cmd; upd_key = key; upd_size = size;
    @(negedge clk);
    upd_vld = 1'b0;
    @(negedge clk);
    c_lv = lv0_vld; c_id = lv0_id; c_k = lv0_key; c_s = lv0_size; c_em = lv0_empty;
    c_ev = err_vld; c_ec = err_code;
  endtask

  task automatic lut(input logic [7:0] id, input logic [1:0] lvl);
    @(negedge clk);
    lut_vld = 1'b1; lut_id = id; lut_level = lvl;
    @(negedge clk);
    lut_vld = 1'b0;
    n_cmp++;
    if (lut_rvld !== 1'b1) begin n_bad++; $display("FAIL lut_vld got %b exp 1", lut_rvld); end
    r_err = lut_err; r_k = lut_key; r_s = lut_size; r_ls = lut_ls;
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_cmp++; if ({upd_rdy, busy, lv0_vld, err_vld, lut_rvld, lut_err} !== 6'b100000) begin n_bad++; $display("FAIL reset_ctl got %b exp 100000", {upd_rdy, busy, lv0_vld, err_vld, lut_rvld, lut_err}); end
    n_cmp++; if ({lut_key, lut_size, lut_ls, lv0_key, lv0_size} !== '0) begin n_bad++; $display("FAIL reset_data got %h exp 0", {lut_key, lut_size, lut_ls, lv0_key, lv0_size}); end
  endtask

  task automatic test_add_sort;
    upd(3, 1, 30, 1);
    n_cmp++; if ({c_lv, c_id, c_k, c_s, c_em, c_ev} !== {1'b1, 8'd3, 32'd30, 32'd1, 1'b0, 1'b0}) begin n_bad++; $display("FAIL add30 got lv=%b id=%0d k=%0d s=%0d em=%b ev=%b exp 1 3 30 1 0 0", c_lv, c_id, c_k, c_s, c_em, c_ev); end
    upd(3, 1, 10, 2);
    n_cmp++; if ({c_lv, c_k, c_s, c_ev} !== {1'b1, 32'd10, 32'd2, 1'b0}) begin n_bad++; $display("FAIL add10 got lv=%b k=%0d s=%0d ev=%b exp 1 10 2 0", c_lv, c_k, c_s, c_ev); end
    upd(3, 1, 20, 3);
    n_cmp++; if ({c_lv, c_ev} !== 2'b00) begin n_bad++; $display("FAIL add20 got lv=%b ev=%b exp 0 0", c_lv, c_ev); end
    lut(3, 0);
    n_cmp++; if ({r_err, r_k, r_s, r_ls} !== {1'b0, 32'd10, 32'd2, 3'd3}) begin n_bad++; $display("FAIL lut3_l0 got e=%b k=%0d s=%0d ls=%0d exp 0 10 2 3", r_err, r_k, r_s, r_ls); end
    lut(3, 1);
    n_cmp++; if ({r_err, r_k, r_s} !== {1'b0, 32'd20, 32'd3}) begin n_bad++; $display("FAIL lut3_l1 got e=%b k=%0d s=%0d exp 0 20 3", r_err, r_k, r_s); end
    lut(3, 2);
    n_cmp++; if ({r_err, r_k, r_s} !== {1'b0, 32'd30, 32'd1}) begin n_bad++; $display("FAIL lut3_l2 got e=%b k=%0d s=%0d exp 0 30 1", r_err, r_k, r_s); end
    lut(3, 3);
    n_cmp++; if ({r_err, r_k, r_s, r_ls} !== {1'b1, 32'd0, 32'd0, 3'd3}) begin n_bad++; $display("FAIL lut3_l3 got e=%b k=%0d s=%0d ls=%0d exp 1 0 0 3", r_err, r_k, r_s, r_ls); end
  endtask

  task automatic test_full;
    upd(0, 1, 40, 4);
    upd(0, 1, 5, 5);
    upd(0, 1, 77, 6);
    upd(0, 1, 60, 7);
    n_cmp++; if ({c_lv, c_ev} !== 2'b00) begin n_bad++; $display("FAIL fill4 got lv=%b ev=%b exp 0 0", c_lv, c_ev); end
    upd(0, 1, 99, 8);
    n_cmp++; if ({c_lv, c_ev, c_ec} !== {1'b0, 1'b1, 2'd1}) begin n_bad++; $display("FAIL full got lv=%b ev=%b code=%0d exp 0 1 1", c_lv, c_ev, c_ec); end
    lut(0, 3);
    n_cmp++; if ({r_err, r_k, r_s, r_ls} !== {1'b0, 32'd77, 32'd6, 3'd4}) begin n_bad++; $display("FAIL full_lut got e=%b k=%0d s=%0d ls=%0d exp 0 77 6 4", r_err, r_k, r_s, r_ls); end
  endtask

  task automatic test_delete;
    upd(3, 2, 10, 0);
    n_cmp++; if ({c_lv, c_k, c_s, c_em, c_ev} !== {1'b1, 32'd20, 32'd3, 1'b0, 1'b0}) begin n_bad++; $display("FAIL del_head got lv=%b k=%0d s=%0d em=%b ev=%b exp 1 20 3 0 0", c_lv, c_k, c_s, c_em, c_ev); end
    upd(3, 2, 55, 0);
    n_cmp++; if ({c_lv, c_ev, c_ec} !== {1'b0, 1'b1, 2'd3}) begin n_bad++; $display("FAIL del_absent got lv=%b ev=%b code=%0d exp 0 1 3", c_lv, c_ev, c_ec); end
    lut(3, 1);
    n_cmp++; if ({r_err, r_k, r_ls} !== {1'b0, 32'd30, 3'd2}) begin n_bad++; $display("FAIL del_lut got e=%b k=%0d ls=%0d exp 0 30 2", r_err, r_k, r_ls); end
  endtask

  task automatic test_replace_dup;
    upd(3, 3, 20, 7);
    n_cmp++; if ({c_lv, c_k, c_s, c_ev} !== {1'b1, 32'd20, 32'd7, 1'b0}) begin n_bad++; $display("FAIL replace got lv=%b k=%0d s=%0d ev=%b exp 1 20 7 0", c_lv, c_k, c_s, c_ev); end
    upd(3, 3, 21, 9);
    n_cmp++; if ({c_lv, c_ev, c_ec} !== {1'b0, 1'b1, 2'd3}) begin n_bad++; $display("FAIL replace_absent got lv=%b ev=%b code=%0d exp 0 1 3", c_lv, c_ev, c_ec); end
    upd(3, 1, 30, 9);
    n_cmp++; if ({c_lv, c_ev, c_ec} !== {1'b0, 1'b1, 2'd2}) begin n_bad++; $display("FAIL dup got lv=%b ev=%b code=%0d exp 0 1 2", c_lv, c_ev, c_ec); end
  endtask

  task automatic test_clear;
    upd(3, 0, 0, 0);
    n_cmp++; if ({c_lv, c_em, c_k, c_s, c_ev} !== {1'b1, 1'b1, 32'd0, 32'd0, 1'b0}) begin n_bad++; $display("FAIL clear got lv=%b em=%b k=%0d s=%0d ev=%b exp 1 1 0 0 0", c_lv, c_em, c_k, c_s, c_ev); end
    upd(3, 0, 0, 0);
    n_cmp++; if ({c_lv, c_ev} !== 2'b00) begin n_bad++; $display("FAIL clear_empty got lv=%b ev=%b exp 0 0", c_lv, c_ev); end
    lut(3, 0);
    n_cmp++; if ({r_err, r_ls} !== {1'b1, 3'd0}) begin n_bad++; $display("FAIL clear_lut got e=%b ls=%0d exp 1 0", r_err, r_ls); end
  endtask

  task automatic test_badid;
    upd(200, 1, 1, 1);
    n_cmp++; if ({c_lv, c_ev, c_ec} !== {1'b0, 1'b1, 2'd0}) begin n_bad++; $display("FAIL badid got lv=%b ev=%b code=%0d exp 0 1 0", c_lv, c_ev, c_ec); end
    lut(200, 0);
    n_cmp++; if ({r_err, r_ls, r_k} !== {1'b1, 3'd0, 32'd0}) begin n_bad++; $display("FAIL badid_lut got e=%b ls=%0d k=%0d exp 1 0 0", r_err, r_ls, r_k); end
  endtask

  task automatic test_back_to_back;
    logic [3:0] rdy_seq, busy_seq;
    @(negedge clk);
    upd_vld = 1'b1; upd_id = 5; upd_cmd = 1; upd_key = 1; upd_size = 1;
    for (int i = 0; i < 4; i++) begin
      rdy_seq[i] = upd_rdy;
      busy_seq[i] = busy;
      lut_vld = (i == 1); lut_id = 5; lut_level = 0;
      if (i == 2) begin
        n_cmp++; if ({lut_err, lut_ls} !== {1'b1, 3'd0}) begin n_bad++; $display("FAIL lut_during_exec got e=%b ls=%0d exp 1 0", lut_err, lut_ls); end
      end
      if (i == 3) upd_vld = 1'b0;
      @(negedge clk);
    end
    n_cmp++; if (rdy_seq !== 4'b0101) begin n_bad++; $display("FAIL b2b_rdy got %b exp 0101", rdy_seq); end
    n_cmp++; if (busy_seq !== 4'b1010) begin n_bad++; $display("FAIL b2b_busy got %b exp 1010", busy_seq); end
    n_cmp++; if ({err_vld, err_code} !== {1'b1, 2'd2}) begin n_bad++; $display("FAIL b2b_dup got ev=%b code=%0d exp 1 2", err_vld, err_code); end
    lut(5, 0);
    n_cmp++; if ({r_err, r_k, r_ls} !== {1'b0, 32'd1, 3'd1}) begin n_bad++; $display("FAIL b2b_lut got e=%b k=%0d ls=%0d exp 0 1 1", r_err, r_k, r_ls); end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    upd_vld = 1'b1; upd_id = 6; upd_cmd = 1; upd_key = 4; upd_size = 4;
    @(negedge clk);
    upd_vld = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if ({lv0_vld, err_vld, upd_rdy, busy} !== 4'b0010) begin n_bad++; $display("FAIL rst_mid got %b exp 0010", {lv0_vld, err_vld, upd_rdy, busy}); end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if ({lv0_vld, err_vld} !== 2'b00) begin n_bad++; $display("FAIL rst_mid_pulse got %b exp 00", {lv0_vld, err_vld}); end
    lut(6, 0);
    n_cmp++; if ({r_err, r_ls} !== {1'b1, 3'd0}) begin n_bad++; $display("FAIL rst_ctx6 got e=%b ls=%0d exp 1 0", r_err, r_ls); end
    lut(0, 0);
    n_cmp++; if ({r_err, r_ls} !== {1'b1, 3'd0}) begin n_bad++; $display("FAIL rst_ctx0 got e=%b ls=%0d exp 1 0", r_err, r_ls); end
    lut(5, 0);
    n_cmp++; if ({r_err, r_ls} !== {1'b1, 3'd0}) begin n_bad++; $display("FAIL rst_ctx5 got e=%b ls=%0d exp 1 0", r_err, r_ls); end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_reset;
    test_add_sort;
    test_full;
    test_delete;
    test_replace_dup;
    test_clear;
    test_badid;
    test_back_to_back;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
